// File: rtl/tetris_input_ctrl.sv
// tetris_input_ctrl: keycode to one-frame command pulses with DAS auto-repeat, plus level-scaled gravity tick.
// Ports:
//   frame_clk    frame clock, all state updates on posedge
//   Reset        synchronous active-high reset
//   keycode      USB HID keycode, 0x00 = no key
//   enable       game running; low pauses pulses and gravity
//   level        game level 0..15, sets gravity period
//   move_left    pulse for A (0x04), auto-repeats
//   move_right   pulse for D (0x07), auto-repeats
//   rotate       pulse for W (0x1A), once per press
//   soft_drop    pulse for S (0x16), repeats while held
//   hard_drop    pulse for space (0x2C), once per press
//   gravity_tick pulse, piece falls one row
module tetris_input_ctrl #(
    parameter int DAS_DELAY   = 10,
    parameter int DAS_PERIOD  = 3,
    parameter int SOFT_PERIOD = 2,
    parameter int GRAV_BASE   = 50,
    parameter int GRAV_STEP   = 4,
    parameter int GRAV_MIN    = 4
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic [7:0] keycode,
    input  logic       enable,
    input  logic [3:0] level,
    output logic       move_left,
    output logic       move_right,
    output logic       rotate,
    output logic       soft_drop,
    output logic       hard_drop,
    output logic       gravity_tick
);
    localparam logic [7:0] K_LEFT   = 8'h04;
    localparam logic [7:0] K_RIGHT  = 8'h07;
    localparam logic [7:0] K_ROT    = 8'h1A;
    localparam logic [7:0] K_SOFT   = 8'h16;
    localparam logic [7:0] K_HARD   = 8'h2C;
    localparam logic [7:0] DLY_END  = 8'(DAS_DELAY - 1);
    localparam logic [7:0] DAS_END  = 8'(DAS_PERIOD - 1);
    localparam logic [7:0] SOFT_END = 8'(SOFT_PERIOD - 1);
    localparam logic [9:0] G_BASE   = 10'(GRAV_BASE);
    localparam logic [9:0] G_STEP   = 10'(GRAV_STEP);
    localparam logic [9:0] G_MIN    = 10'(GRAV_MIN);

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT, HOLD} state_t;

    state_t     state, state_n;
    logic [7:0] key, key_n, das_cnt, das_n, pulse_key;
    logic [9:0] grav_cnt, grav_n, sub, diff, period, grav_end;
    logic       mapped, press, due, mv, drop, tick_n;

    assign mapped = keycode == K_LEFT || keycode == K_RIGHT || keycode == K_ROT ||
                    keycode == K_SOFT || keycode == K_HARD;
    // a different mapped key while one is held restarts the FSM as a fresh press
    assign press  = mapped && (state == IDLE || keycode != key);

    always_comb begin
        state_n   = state;
        key_n     = key;
        das_n     = das_cnt;
        pulse_key = '0;
        if (!enable || (!press && !mapped)) begin
            state_n = IDLE;
            key_n   = '0;
            das_n   = '0;
        end else if (press) begin
            pulse_key = keycode;
            key_n     = keycode;
            das_n     = '0;
            state_n   = (keycode == K_LEFT || keycode == K_RIGHT) ? DELAY :
                        (keycode == K_SOFT) ? REPEAT : HOLD;
        end else if (state == DELAY) begin
            pulse_key = (das_cnt == DLY_END) ? key : '0;
            state_n   = (das_cnt == DLY_END) ? REPEAT : DELAY;
            das_n     = (das_cnt == DLY_END) ? '0 : das_cnt + 8'd1;
        end else if (state == REPEAT) begin
            pulse_key = (das_cnt == ((key == K_SOFT) ? SOFT_END : DAS_END)) ? key : '0;
            das_n     = (das_cnt == ((key == K_SOFT) ? SOFT_END : DAS_END)) ? '0 : das_cnt + 8'd1;
        end
    end

    // period = max(GRAV_MIN, GRAV_BASE - level*GRAV_STEP), clamping on unsigned underflow
    assign sub      = {6'd0, level} * G_STEP;
    assign diff     = G_BASE - sub;
    assign period   = (sub > G_BASE || diff < G_MIN) ? G_MIN : diff;
    assign grav_end = period - 10'd1;
    // >= so a level change that shrinks the period below the count fires on the next cycle
    assign due      = grav_cnt >= grav_end;
    assign mv       = pulse_key == K_LEFT || pulse_key == K_RIGHT || pulse_key == K_ROT;
    assign drop     = pulse_key == K_SOFT || pulse_key == K_HARD;

    // a due tick colliding with a move is deferred by holding the count
    always_comb begin
        grav_n = !enable ? grav_cnt : drop ? '0 : !due ? grav_cnt + 10'd1 : mv ? grav_cnt : '0;
        tick_n = enable && !drop && due && !mv;
    end

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state        <= IDLE;
            key          <= '0;
            das_cnt      <= '0;
            grav_cnt     <= '0;
            move_left    <= 1'b0;
            move_right   <= 1'b0;
            rotate       <= 1'b0;
            soft_drop    <= 1'b0;
            hard_drop    <= 1'b0;
            gravity_tick <= 1'b0;
        end else begin
            state        <= state_n;
            key          <= key_n;
            das_cnt      <= das_n;
            grav_cnt     <= grav_n;
            move_left    <= pulse_key == K_LEFT;
            move_right   <= pulse_key == K_RIGHT;
            rotate       <= pulse_key == K_ROT;
            soft_drop    <= pulse_key == K_SOFT;
            hard_drop    <= pulse_key == K_HARD;
            gravity_tick <= tick_n;
        end
    end
endmodule
